// File: rtl/mouse_brush_stamper_pkg.sv
// Shared types and default playfield geometry for the falling-sand brush path.
package falling_sand_pkg;

   localparam int unsigned DEFAULT_COLUMNS = 640;
   localparam int unsigned DEFAULT_ROWS    = 400;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } brush_state_t;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      SAND  = 2'b01,
      WATER = 2'b10,
      WALL  = 2'b11
   } particle_t;

endpackage

// File: rtl/mouse_brush_stamper_if.sv
// VRAM write-port bus between the brush stamper and the write-port mux.
interface mouse_brush_stamper_if #(
   parameter int unsigned ADDR_WIDTH = $clog2(640 * 400),
   parameter int unsigned DATA_WIDTH = 2
);
   logic [ADDR_WIDTH-1:0] wr_address_o;
   logic [DATA_WIDTH-1:0] wr_data_o;
   logic                  wr_en_o;
   logic                  grant_i;

   modport master (
      output wr_address_o,
      output wr_data_o,
      output wr_en_o,
      input  grant_i
   );

   modport slave (
      input  wr_address_o,
      input  wr_data_o,
      input  wr_en_o,
      output grant_i
   );
endinterface

// File: rtl/mouse_brush_stamper_axis_clip.sv
// Clips one brush axis [pos-R, pos+R] to [0, LIMIT-1].
module brush_axis_clip #(
   parameter int unsigned LIMIT = 640,
   parameter int unsigned R     = 2,
   parameter int unsigned W     = $clog2(LIMIT)
) (
   input  logic [W-1:0] pos,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);
   localparam logic [W:0] R_EXT   = (W+1)'(R);
   localparam logic [W:0] MAX_EXT = (W+1)'(LIMIT - 1);

   logic [W:0] pos_ext;
   logic [W:0] sum;

   // Extended by one bit so pos+R cannot wrap before the upper clamp.
   always_comb begin
      pos_ext = {1'b0, pos};
      sum     = pos_ext + R_EXT;
      lo      = (pos_ext < R_EXT) ? '0 : W'(pos_ext - R_EXT);
      hi      = (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
   end
endmodule

// File: rtl/mouse_brush_stamper.sv
// Paints a clipped square brush around the cursor into VRAM, one pixel per
// granted cycle, in row-major order.
// Optional: BRUSH_SKIP_REPEAT_EN suppresses a stamp identical to the last
// completed one (same x, y and type).
module mouse_brush_stamper
   import falling_sand_pkg::*;
#(
   parameter int unsigned COLUMNS      = DEFAULT_COLUMNS,
   parameter int unsigned ROWS         = DEFAULT_ROWS,
   parameter int unsigned ADDR_WIDTH   = $clog2(COLUMNS * ROWS),
   parameter int unsigned DATA_WIDTH   = 2,
   parameter int unsigned BRUSH_RADIUS = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       draw_en_i,
   input  logic [DATA_WIDTH-1:0]      pixel_type_i,
   input  logic [$clog2(COLUMNS)-1:0] mouse_x_position_i,
   input  logic [$clog2(ROWS)-1:0]    mouse_y_position_i,
   mouse_brush_stamper_if.master      vram,
   output logic                       busy_o,
   output logic                       stamp_done_o
);
   localparam int unsigned XW = $clog2(COLUMNS);
   localparam int unsigned YW = $clog2(ROWS);

   brush_state_t state_q, state_d;

   logic [XW-1:0]         x_q, x0_q, x1_q, col_q;
   logic [YW-1:0]         y_q, y1_q, row_q;
   logic [DATA_WIDTH-1:0] type_q;
   logic [ADDR_WIDTH-1:0] row_base_q;

   logic [XW-1:0] x_lo, x_hi;
   logic [YW-1:0] y_lo, y_hi;
   logic          repeat_hit;
   logic          start;
   logic          last_pixel;

   brush_axis_clip #(.LIMIT(COLUMNS), .R(BRUSH_RADIUS), .W(XW)) u_clip_x (
      .pos (x_q),
      .lo  (x_lo),
      .hi  (x_hi)
   );

   brush_axis_clip #(.LIMIT(ROWS), .R(BRUSH_RADIUS), .W(YW)) u_clip_y (
      .pos (y_q),
      .lo  (y_lo),
      .hi  (y_hi)
   );

`ifdef BRUSH_SKIP_REPEAT_EN
   logic [XW-1:0]         last_x_q;
   logic [YW-1:0]         last_y_q;
   logic [DATA_WIDTH-1:0] last_type_q;
   logic                  last_valid_q;

   // Remember the parameters of the last stamp that ran to completion.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         last_x_q     <= '0;
         last_y_q     <= '0;
         last_type_q  <= '0;
         last_valid_q <= 1'b0;
      end else if (state_q == DONE) begin
         last_x_q     <= x_q;
         last_y_q     <= y_q;
         last_type_q  <= type_q;
         last_valid_q <= 1'b1;
      end
   end

   // A request matching the last completed stamp would rewrite identical pixels.
   always_comb begin
      repeat_hit = last_valid_q &&
                   (mouse_x_position_i == last_x_q) &&
                   (mouse_y_position_i == last_y_q) &&
                   (pixel_type_i == last_type_q);
   end
`else
   // Every acceptance performs a full stamp.
   always_comb begin
      repeat_hit = 1'b0;
   end
`endif

   // Acceptance and end-of-brush decode shared by the FSM and datapath.
   always_comb begin
      start      = (state_q == IDLE) && draw_en_i && !repeat_hit;
      last_pixel = (col_q == x1_q) && (row_q == y1_q);
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = SETUP;
         SETUP: state_d = WRITE;
         WRITE: if (vram.grant_i && last_pixel) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the request, register the clipped window, then walk it row-major.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         x_q        <= '0;
         y_q        <= '0;
         type_q     <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  x_q    <= mouse_x_position_i;
                  y_q    <= mouse_y_position_i;
                  type_q <= pixel_type_i;
               end
            end
            SETUP: begin
               x0_q       <= x_lo;
               x1_q       <= x_hi;
               y1_q       <= y_hi;
               col_q      <= x_lo;
               row_q      <= y_lo;
               // Only multiply in the design; rows afterwards advance by adding COLUMNS.
               row_base_q <= ADDR_WIDTH'(y_lo) * ADDR_WIDTH'(COLUMNS);
            end
            WRITE: begin
               if (vram.grant_i) begin
                  if (col_q < x1_q) begin
                     col_q <= col_q + XW'(1);
                  end else begin
                     col_q      <= x0_q;
                     row_q      <= row_q + YW'(1);
                     row_base_q <= row_base_q + ADDR_WIDTH'(COLUMNS);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign vram.wr_en_o      = (state_q == WRITE);
   assign vram.wr_address_o = (state_q == WRITE) ? (row_base_q + ADDR_WIDTH'(col_q)) : '0;
   assign vram.wr_data_o    = (state_q == WRITE) ? type_q : '0;
   assign busy_o            = (state_q != IDLE);
   assign stamp_done_o      = (state_q == DONE);

endmodule

// File: tb/tb_mouse_brush_stamper.sv
// Directed, table-driven bench for mouse_brush_stamper.
module tb_mouse_brush_stamper;
   import falling_sand_pkg::*;

   localparam int AMAX = 640 * 400 - 1;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       draw_en_i = 1'b0;
   logic [1:0] pixel_type_i = '0;
   logic [9:0] mouse_x_position_i = '0;
   logic [8:0] mouse_y_position_i = '0;
   logic       busy_o;
   logic       stamp_done_o;

   mouse_brush_stamper_if #(.ADDR_WIDTH(18), .DATA_WIDTH(2)) vram ();

   mouse_brush_stamper #(
      .COLUMNS(640), .ROWS(400), .ADDR_WIDTH(18), .DATA_WIDTH(2), .BRUSH_RADIUS(2)
   ) dut (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .draw_en_i          (draw_en_i),
      .pixel_type_i       (pixel_type_i),
      .mouse_x_position_i (mouse_x_position_i),
      .mouse_y_position_i (mouse_y_position_i),
      .vram               (vram),
      .busy_o             (busy_o),
      .stamp_done_o       (stamp_done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int x, y, t;
      int x0, x1, y0, y1;
      int n, first, last, done;
   } vec_t;

   int tests = 0;
   int fails = 0;

   // Results of the most recent run_stamp call.
   int n_w, done_c, data_err, max_a, held_err, busy1;
   int cap [0:63];

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Pulse draw_en for one cycle, scramble the inputs, then observe the stamp.
   // Cycle k counts posedges since the request was latched.
   task automatic run_stamp(input int x, input int y, input int t,
                            input int stall_at, input int stall_len,
                            input int held_exp, input int budget);
      int stall_left;
      n_w = 0; done_c = -1; data_err = 0; max_a = 0; held_err = 0; busy1 = 0;
      @(negedge clk_i);
      mouse_x_position_i = 10'(x);
      mouse_y_position_i = 9'(y);
      pixel_type_i       = 2'(t);
      draw_en_i          = 1'b1;
      @(negedge clk_i);
      draw_en_i          = 1'b0;
      mouse_x_position_i = 10'(x ^ 37);
      mouse_y_position_i = 9'(y ^ 11);
      pixel_type_i       = ~2'(t);
      stall_left = stall_len;
      for (int k = 1; k <= budget; k++) begin
         if (n_w == stall_at && stall_left > 0 && vram.wr_en_o) begin
            vram.grant_i = 1'b0;
            stall_left--;
            if (int'(vram.wr_address_o) != held_exp) held_err++;
         end else begin
            vram.grant_i = 1'b1;
         end
         if (k == 1) busy1 = int'(busy_o);
         if (vram.wr_en_o && vram.grant_i) begin
            if (n_w < 64) cap[n_w] = int'(vram.wr_address_o);
            if (int'(vram.wr_data_o) != t) data_err++;
            if (int'(vram.wr_address_o) > max_a) max_a = int'(vram.wr_address_o);
            n_w++;
         end
         if (stamp_done_o) begin
            done_c = k;
            break;
         end
         @(negedge clk_i);
      end
      vram.grant_i = 1'b1;
   endtask

   vec_t tbl [5];
   int   tl [9];
   int   seen, hit, cnt, bcnt, w, ord_err, exp_a;

   initial begin
      tbl[0] = '{x:100, y:50,  t:1, x0:98,  x1:102, y0:48,  y1:52,  n:25, first:30818,  last:33382,  done:27};
      tbl[1] = '{x:0,   y:0,   t:2, x0:0,   x1:2,   y0:0,   y1:2,   n:9,  first:0,      last:1282,   done:11};
      tbl[2] = '{x:639, y:399, t:3, x0:637, x1:639, y0:397, y1:399, n:9,  first:254717, last:255999, done:11};
      tbl[3] = '{x:1,   y:200, t:0, x0:0,   x1:3,   y0:198, y1:202, n:20, first:126720, last:129283, done:22};
      tbl[4] = '{x:638, y:1,   t:1, x0:636, x1:639, y0:0,   y1:3,   n:16, first:636,    last:2559,   done:18};
      tl = '{0, 1, 2, 640, 641, 642, 1280, 1281, 1282};

      vram.grant_i = 1'b1;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst_wr_en", vram.wr_en_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", stamp_done_o, 0);
      check("rst_addr", vram.wr_address_o, 0);
      check("rst_data", vram.wr_data_o, 0);
      reset_i = 1'b1;

      // Table of stamps with grant always high
      for (int i = 0; i < 5; i++) begin
         run_stamp(tbl[i].x, tbl[i].y, tbl[i].t, -1, 0, 0, 100);
         check($sformatf("v%0d_count", i), n_w, tbl[i].n);
         check($sformatf("v%0d_first", i), cap[0], tbl[i].first);
         check($sformatf("v%0d_last", i), (n_w > 0 && n_w <= 64) ? cap[n_w-1] : -1, tbl[i].last);
         check($sformatf("v%0d_done_cycle", i), done_c, tbl[i].done);
         check($sformatf("v%0d_data", i), data_err, 0);
         check($sformatf("v%0d_addr_bound", i), (max_a > AMAX) ? 1 : 0, 0);
         check($sformatf("v%0d_busy", i), busy1, 1);
         w = tbl[i].x1 - tbl[i].x0 + 1;
         ord_err = 0;
         for (int j = 0; j < n_w && j < 64; j++) begin
            exp_a = (tbl[i].y0 + j / w) * 640 + tbl[i].x0 + j % w;
            if (cap[j] != exp_a) ord_err++;
         end
         check($sformatf("v%0d_order", i), ord_err, 0);
      end

      // Top-left corner: explicit write sequence
      run_stamp(0, 0, 2, -1, 0, 0, 100);
      check("tl_count", n_w, 9);
      for (int j = 0; j < 9; j++) check($sformatf("tl_addr%0d", j), cap[j], tl[j]);

      // Stall of 3 cycles after the 5th commit
      run_stamp(100, 50, 1, 5, 3, 31458, 100);
      check("stall_count", n_w, 25);
      check("stall_held_addr", held_err, 0);
      check("stall_done_cycle", done_c, 30);
      check("stall_6th_addr", cap[5], 31458);

      // Reset asserted while the 10th write is presented
      @(negedge clk_i);
      mouse_x_position_i = 10'd300; mouse_y_position_i = 9'd200;
      pixel_type_i = 2'(WATER); draw_en_i = 1'b1;
      @(negedge clk_i);
      draw_en_i = 1'b0;
      seen = 0; hit = 0;
      for (int k = 0; k < 40; k++) begin
         if (vram.wr_en_o) begin
            if (seen == 9) begin
               reset_i = 1'b0;
               #1;
               hit = 1;
               break;
            end
            seen++;
         end
         @(negedge clk_i);
      end
      check("midrst_reached", hit, 1);
      check("midrst_wr_en", vram.wr_en_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_done", stamp_done_o, 0);
      @(negedge clk_i);
      reset_i = 1'b1;
      cnt = 0; bcnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk_i);
         if (vram.wr_en_o) cnt++;
         if (busy_o || stamp_done_o) bcnt++;
      end
      check("postrst_writes", cnt, 0);
      check("postrst_busy", bcnt, 0);

      // Repeated identical stamp, then a one-column move
      run_stamp(320, 240, 1, -1, 0, 0, 100);
      check("rep1_count", n_w, 25);
      check("rep1_done_cycle", done_c, 27);
      run_stamp(320, 240, 1, -1, 0, 0, 40);
`ifdef BRUSH_SKIP_REPEAT_EN
      check("rep2_count", n_w, 0);
      check("rep2_done", done_c, -1);
`else
      check("rep2_count", n_w, 25);
      check("rep2_done_cycle", done_c, 27);
`endif
      run_stamp(321, 240, 1, -1, 0, 0, 100);
      check("rep3_count", n_w, 25);
      check("rep3_first", cap[0], 238 * 640 + 319);
      check("rep3_done_cycle", done_c, 27);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
